bcd_seq_adder: RTL and testbench
================================

# bcd_seq_adder

Multi-digit packed-BCD adder controller. It accepts two DIGITS-digit operands and a carry-in over a valid/ready handshake, then sequences one single-digit BCD adder over the digits, least-significant first, one digit per clock. It returns the packed BCD sum and decimal carry-out over a second valid/ready handshake. It sits between a requester (keypad/ALU front end) and the digit-adder datapath, and time-shares one digit adder across all digits.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; clears all state
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- ci  in  1  decimal carry-in to digit 0
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  4*DIGITS  packed BCD sum
- co  out  1  decimal carry-out of the top digit
- err  out  1  at least one input digit was >9

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, and ci→carry. Clear sum, err and idx. Set err if any digit of a or b is >9. Go to ADD.
- ADD: in_ready=0. Digit adder input is a[idx], b[idx], carry. Compute t=a_d+b_d+carry (5-bit, up to 31 for illegal digits):
  - If t>9: digit=(t+6) mod 16, carry_out=1.
  - Otherwise: digit=t, carry_out=0.
  - Write the digit to sum[idx] and carry_out to carry, then increment idx.
  - If idx==DIGITS-1, go to DONE instead of incrementing.
- DONE: out_valid=1, co=carry. sum, co and err stay stable until out_ready. On out_valid&out_ready, go to IDLE.
- a, b and ci are ignored outside the accept cycle. out_ready is ignored outside DONE.
- Illegal digits are not trapped: the correction rule above still applies and err flags the result. Example: digit A(10)+0 gives digit 0, carry 1.
- The idx width is max(1, $clog2(DIGITS)). With DIGITS=1, ADD lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, in_ready=1 once rst deasserts (0 while rst is high), out_valid=0, sum=0, co=0, err=0, idx=0, carry=0.
- Accept at edge E0. Digit i is written at edge E0+1+i. DONE is entered at edge E0+DIGITS, so out_valid is high from E0+DIGITS.
- Latency from accept edge to out_valid is DIGITS cycles.
- Throughput is one operation per DIGITS+2 cycles minimum. The next accept can happen at the edge after the output handshake edge; in_ready rises in that cycle.
- A result is held indefinitely under out_ready=0 back-pressure. No output glitches while held.
- rst asserted mid-ADD or mid-DONE aborts the operation immediately. The result is lost and out_valid never pulses for it.
- in_valid asserted during ADD or DONE is not accepted. The requester must hold it until in_ready.
- There are no combinational paths from in_valid to in_ready or from out_ready to out_valid. Both readies are decoded from state only.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, ADD, DONE)
  - 4-bit bcd_digit_t
  - constants BCD_MAX=9 and BCD_CORR=6
  - function is_bcd(digit)
- Sub-module bcd_digit_add: combinational digit adder. Inputs are digit a, digit b and ci; outputs are digit s and co, using the t>9 correction rule. It is instantiated once and muxed by idx.
- All other logic (FSM, idx counter, carry register, sum register with per-digit write enable, err flag) lives in bcd_seq_adder.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, ci=0, out_ready=1 -> sum=0x6912, co=0, err=0. out_valid rises exactly 4 cycles after the accept edge.
- a=0x9999, b=0x0001, ci=0 -> sum=0x0000, co=1. With ci=1 instead -> sum=0x0001, co=1. a=0, b=0, ci=1 -> sum=0x0001, co=0.
- Back-pressure: a=0x0500, b=0x0500, out_ready=0 for 10 cycles -> sum=0x1000, co=0 held stable with out_valid=1 and in_ready=0. in_valid pulses during the hold are ignored. Release out_ready -> in_ready=1 the next cycle.
- Illegal digit: a=0x000A, b=0x0000, ci=0 -> sum=0x0010, co=0, err=1. The next legal operation returns err=0.
- Reset mid-op: accept 0x1111+0x2222, assert rst at accept+2 cycles -> out_valid, sum, co and err are all 0 and in_ready=1 after release. A fresh 0x0001+0x0001 then returns 0x0002.
- Back-to-back: two operations issued with in_valid held high -> the second is accepted at the edge after the first output handshake, and both results are correct in order.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        // Illegal digits can push t up to 31; only the low nibble matters after correction.
        if (t > {1'b0, BCD_MAX}) begin
            s  = t[3:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            s  = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-digit packed-BCD adder that time-shares one digit adder, LSD first.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  ci,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  co,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    state_t                     state;
    state_t                     state_n;
    logic                       accept;
    logic [IW-1:0]              idx;
    logic                       carry;
    logic                       err_r;
    logic                       in_err;
    bcd_digit_t [DIGITS-1:0]    a_r;
    bcd_digit_t [DIGITS-1:0]    b_r;
    bcd_digit_t [DIGITS-1:0]    sum_r;
    bcd_digit_t                 d_s;
    logic                       d_co;

    bcd_digit_add u_digit_add (
        .a  (a_r[idx]),
        .b  (b_r[idx]),
        .ci (carry),
        .s  (d_s),
        .co (d_co)
    );

    always_comb begin
        in_err = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4]))
                in_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                if (idx == IDX_LAST)
                    state_n = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            err_r <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sum_r <= '0;
            carry <= ci;
            err_r <= in_err;
            idx   <= '0;
        end else if (state == ADD) begin
            sum_r[idx] <= d_s;
            carry      <= d_co;
            if (idx != IDX_LAST)
                idx <= idx + 1'b1;
        end
    end

    assign sum = sum_r;
    assign co  = carry;
    assign err = err_r;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder against a decimal-arithmetic reference.
module tb_bcd_seq_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         err;

    int checks   = 0;
    int failures = 0;

    bcd_seq_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        int m = 1;
        logic [W-1:0] t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r += int'(t[3:0]) * m;
            m *= 10;
            t = t >> 4;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int pow10_digits();
        int m = 1;
        for (int i = 0; i < DIGITS; i++) m *= 10;
        return m;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Drives one transaction and returns what appeared at the output; out_ready stays 1.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                          output logic [W-1:0] rs, output logic rco, output logic rerr,
                          output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) tmo = 1'b1;
        rs = sum; rco = co; rerr = err;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || co !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b sum=%h co=%b err=%b exp 1 0 0000 0 0",
                     in_ready, out_valid, sum, co, err);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h1234, 16'h9999, 16'h9999, 16'h0000, 16'h9999};
        logic [W-1:0] vb [5] = '{16'h5678, 16'h0001, 16'h0001, 16'h0000, 16'h9999};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] es [5] = '{16'h6912, 16'h0000, 16'h0001, 16'h0001, 16'h9999};
        logic         ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] rs; logic rco, rerr; int lat; bit tmo;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], rs, rco, rerr, lat, tmo);
            checks++;
            if (tmo || rs !== es[i] || rco !== ec[i] || rerr !== 1'b0) begin
                failures++;
                $display("FAIL directed_%0d got sum=%h co=%b err=%b tmo=%b exp sum=%h co=%b err=0",
                         i, rs, rco, rerr, tmo, es[i], ec[i]);
            end
            checks++;
            if (lat != DIGITS) begin
                failures++; $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, DIGITS);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_v, rs, es; logic tci, rco, rerr, ec; int lat, tot; bit tmo;
        for (int i = 0; i < 20; i++) begin
            ta = rand_bcd(); tb_v = rand_bcd(); tci = 1'($urandom);
            tot = bcd2int(ta) + bcd2int(tb_v) + int'(tci);
            ec  = (tot >= pow10_digits());
            es  = int2bcd(tot % pow10_digits());
            run_op(ta, tb_v, tci, rs, rco, rerr, lat, tmo);
            checks++;
            if (tmo || rs !== es || rco !== ec || rerr !== 1'b0 || lat != DIGITS) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h ci=%b got sum=%h co=%b err=%b lat=%0d exp sum=%h co=%b err=0 lat=%0d",
                         i, ta, tb_v, tci, rs, rco, rerr, lat, es, ec, DIGITS);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 16'h0500; b = 16'h0500; ci = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL bp_timeout got=no_out_valid exp=out_valid"); end
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 0); a = 16'h4444; b = 16'h3333;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1000 || co !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got out_valid=%b in_ready=%b sum=%h co=%b err=%b exp 1 0 1000 0 0",
                         i, out_valid, in_ready, sum, co, err);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_no_stray_accept got in_ready=%b exp=1", in_ready);
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] rs; logic rco, rerr; int lat; bit tmo;
        run_op(16'h000A, 16'h0000, 1'b0, rs, rco, rerr, lat, tmo);
        checks++;
        if (tmo || rs !== 16'h0010 || rco !== 1'b0 || rerr !== 1'b1) begin
            failures++; $display("FAIL illegal_a got sum=%h co=%b err=%b exp 0010 0 1", rs, rco, rerr);
        end
        run_op(16'h000F, 16'h000F, 1'b1, rs, rco, rerr, lat, tmo);
        checks++;
        if (tmo || rs !== 16'h0015 || rco !== 1'b0 || rerr !== 1'b1) begin
            failures++; $display("FAIL illegal_ff got sum=%h co=%b err=%b exp 0015 0 1", rs, rco, rerr);
        end
        run_op(16'h0012, 16'h0034, 1'b0, rs, rco, rerr, lat, tmo);
        checks++;
        if (tmo || rs !== 16'h0046 || rco !== 1'b0 || rerr !== 1'b0) begin
            failures++; $display("FAIL illegal_clear got sum=%h co=%b err=%b exp 0046 0 0", rs, rco, rerr);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] rs; logic rco, rerr; int lat; bit tmo; bit seen;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; ci = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || co !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_state got out_valid=%b sum=%h co=%b err=%b in_ready=%b exp 0 0000 0 0 1",
                     out_valid, sum, co, err, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin failures++; $display("FAIL reset_mid_ghost got out_valid=1 exp=0"); end
        run_op(16'h0001, 16'h0001, 1'b0, rs, rco, rerr, lat, tmo);
        checks++;
        if (tmo || rs !== 16'h0002 || rco !== 1'b0 || rerr !== 1'b0) begin
            failures++; $display("FAIL reset_mid_fresh got sum=%h co=%b err=%b exp 0002 0 0", rs, rco, rerr);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [2]; logic [W-1:0] ob [2]; logic oc [2];
        logic [W-1:0] es [2]; logic ec [2];
        logic [W-1:0] rsum [2]; logic rco [2];
        int acc_cyc [2]; int hs_cyc [2];
        int nacc, nres, cyc, tot;
        for (int i = 0; i < 2; i++) begin
            oa[i] = rand_bcd(); ob[i] = rand_bcd(); oc[i] = 1'($urandom);
            tot = bcd2int(oa[i]) + bcd2int(ob[i]) + int'(oc[i]);
            ec[i] = (tot >= pow10_digits());
            es[i] = int2bcd(tot % pow10_digits());
        end
        nacc = 0; nres = 0; cyc = 0;
        @(negedge clk);
        a = oa[0]; b = ob[0]; ci = oc[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (nres < 2 && cyc < 60) begin
            if (in_ready && in_valid && nacc < 2) begin acc_cyc[nacc] = cyc; nacc++; end
            if (out_valid) begin rsum[nres] = sum; rco[nres] = co; hs_cyc[nres] = cyc; nres++; end
            @(negedge clk);
            cyc++;
            if (nacc == 1) begin a = oa[1]; b = ob[1]; ci = oc[1]; end
            if (nacc == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (nres < 2 || nacc < 2) begin
            failures++; $display("FAIL b2b_timeout got acc=%0d res=%0d exp 2 2", nacc, nres);
        end else begin
            checks++;
            if (acc_cyc[1] != hs_cyc[0] + 1) begin
                failures++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_cyc[1], hs_cyc[0] + 1);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rsum[i] !== es[i] || rco[i] !== ec[i]) begin
                    failures++;
                    $display("FAIL b2b_result_%0d got sum=%h co=%b exp sum=%h co=%b", i, rsum[i], rco[i], es[i], ec[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
